// File: rtl/vga_sync_gen.sv
// VGA raster timing: pixel-rate enable, X/Y counters, visible-area decode,
// plus registered blank-masked colour and active-low syncs on one pixel edge.
module vga_sync_gen #(
   parameter int CLK_DIV   = 2,
   parameter int H_VISIBLE = 640,
   parameter int H_FRONT   = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BACK    = 48,
   parameter int V_VISIBLE = 480,
   parameter int V_FRONT   = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BACK    = 33
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       R,
   input  logic       G,
   input  logic       B,
   output logic [9:0] CounterX,
   output logic [9:0] CounterY,
   output logic       inDisplayArea,
   output logic       PixelTick,
   output logic       FrameTick,
   output logic       vga_r,
   output logic       vga_g,
   output logic       vga_b,
   output logic       vga_h_sync,
   output logic       vga_v_sync
);

   localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
   localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_VIS      = 10'(H_VISIBLE);
   localparam logic [9:0] V_VIS      = 10'(V_VISIBLE);
   localparam logic [9:0] H_VIS_LAST = 10'(H_VISIBLE - 1);
   localparam logic [9:0] V_VIS_LAST = 10'(V_VISIBLE - 1);
   localparam logic [9:0] HS_START   = 10'(H_VISIBLE + H_FRONT);
   localparam logic [9:0] HS_END     = 10'(H_VISIBLE + H_FRONT + H_SYNC);
   localparam logic [9:0] VS_START   = 10'(V_VISIBLE + V_FRONT);
   localparam logic [9:0] VS_END     = 10'(V_VISIBLE + V_FRONT + V_SYNC);

   logic [DIV_W-1:0] DivCnt;
   logic             lineEnd;
   logic             frameEnd;
   logic             hSyncActive;
   logic             vSyncActive;

   // With CLK_DIV=1 DivCnt stays at 0 and the tick is permanently high.
   always_ff @(posedge Clk) begin
      if (!Reset)
         DivCnt <= '0;
      else if (PixelTick)
         DivCnt <= '0;
      else
         DivCnt <= DivCnt + DIV_W'(1);
   end

   assign PixelTick = (DivCnt == DIV_LAST);
   assign lineEnd   = (CounterX == H_LAST);
   assign frameEnd  = (CounterY == V_LAST);

   always_ff @(posedge Clk) begin
      if (!Reset) begin
         CounterX <= '0;
         CounterY <= '0;
      end else if (PixelTick) begin
         CounterX <= lineEnd ? 10'd0 : CounterX + 10'd1;
         if (lineEnd)
            CounterY <= frameEnd ? 10'd0 : CounterY + 10'd1;
      end
   end

   assign inDisplayArea = (CounterX < H_VIS) && (CounterY < V_VIS);
   assign hSyncActive   = (CounterX >= HS_START) && (CounterX < HS_END);
   assign vSyncActive   = (CounterY >= VS_START) && (CounterY < VS_END);
   assign FrameTick     = PixelTick && (CounterX == H_VIS_LAST) && (CounterY == V_VIS_LAST);

   // Colour and syncs share one register stage so the pins stay aligned.
   always_ff @(posedge Clk) begin
      if (!Reset) begin
         vga_r      <= 1'b0;
         vga_g      <= 1'b0;
         vga_b      <= 1'b0;
         vga_h_sync <= 1'b1;
         vga_v_sync <= 1'b1;
      end else if (PixelTick) begin
         vga_r      <= R & inDisplayArea;
         vga_g      <= G & inDisplayArea;
         vga_b      <= B & inDisplayArea;
         vga_h_sync <= ~hSyncActive;
         vga_v_sync <= ~vSyncActive;
      end
   end

endmodule

// File: doc/vga_sync_gen.md
# vga_sync_gen

Generates VGA raster timing for the invaders display: a pixel-rate enable, the horizontal/vertical pixel counters, the visible-area flag and the active-low sync pulses. Its counter outputs feed the drawing logic, which returns combinational R/G/B; those come back into this block and are masked and registered together with the syncs, so the VGA pins change on a single pixel edge. It also issues a once-per-frame pulse that the game logic uses to step alien, player and bullet positions.

## Interface
- CLK_DIV, 2: system clocks per pixel; must be ≥1 (50 MHz → 25 MHz pixel rate)
- H_VISIBLE, 640: visible pixels per line
- H_FRONT, 16: horizontal front porch, pixels
- H_SYNC, 96: horizontal sync width, pixels
- H_BACK, 48: horizontal back porch, pixels
- V_VISIBLE, 480: visible lines per frame
- V_FRONT, 10: vertical front porch, lines
- V_SYNC, 2: vertical sync width, lines
- V_BACK, 33: vertical back porch, lines

- Clk  in  1  system clock; all logic on rising edge
- Reset  in  1  synchronous, active-low (0 = reset)
- R, G, B  in  1 each  pixel colour from the drawing logic for the current CounterX/CounterY
- CounterX  out  10  horizontal pixel position, 0..H_TOTAL-1
- CounterY  out  10  vertical line position, 0..V_TOTAL-1
- inDisplayArea  out  1  CounterX < H_VISIBLE and CounterY < V_VISIBLE
- PixelTick  out  1  one-Clk pulse once per pixel period
- FrameTick  out  1  one-Clk pulse once per frame
- vga_r, vga_g, vga_b  out  1 each  registered, blank-masked colour
- vga_h_sync, vga_v_sync  out  1 each  registered, active-low syncs

## Operation
- H_TOTAL = H_VISIBLE+H_FRONT+H_SYNC+H_BACK (800); V_TOTAL likewise (525). Both must be ≤1024.
- DivCnt counts 0..CLK_DIV-1 on every Clk and wraps. PixelTick = (DivCnt == CLK_DIV-1), decoded from the register. With CLK_DIV=1, PixelTick is constantly 1 outside reset.
- On a Clk edge with PixelTick=1:
  - CounterX increments. At H_TOTAL-1 it wraps to 0.
  - When CounterX wraps, CounterY increments. At V_TOTAL-1 it wraps to 0.
  - vga_r/g/b <= R/G/B AND inDisplayArea, using the values from before the edge.
  - vga_h_sync <= ~(CounterX in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC)), i.e. low for X = 656..751.
  - vga_v_sync <= ~(CounterY in [V_VISIBLE+V_FRONT, V_VISIBLE+V_FRONT+V_SYNC)), i.e. low for Y = 490..491.
- When PixelTick=0, all counters and output registers hold.
- inDisplayArea is a combinational decode of CounterX/CounterY, so it aligns with the combinational colour inputs.
- FrameTick = PixelTick AND CounterX == H_VISIBLE-1 AND CounterY == V_VISIBLE-1. It marks the last visible pixel, so game state updates land during vertical blanking.
- Counter comparisons are unsigned, 10-bit. Parameter sums are evaluated at elaboration, with no runtime arithmetic beyond increment and compare.

## Timing
- Reset (Reset=0 at a Clk edge) forces: DivCnt=0, CounterX=0, CounterY=0, vga_r/g/b=0, vga_h_sync=1, vga_v_sync=1.
  - Consequently PixelTick=0 (for CLK_DIV>1), FrameTick=0 and inDisplayArea=1.
  - Reset wins over any simultaneous tick or wrap, including mid-line or mid-frame.
- After Reset is released, the first PixelTick (CLK_DIV=2) is high in the cycle following the first non-reset edge. The next edge moves CounterX 0→1 and registers pixel (0,0).
- Output latency: vga_* reflect counter position N one pixel period after the counters show N. The syncs and RGB share that latency, so they stay mutually aligned.
- Line period is H_TOTAL×CLK_DIV Clk cycles (1600). Frame period is H_TOTAL×V_TOTAL×CLK_DIV (840000).
- FrameTick is exactly one Clk wide. Consecutive pulses are one frame period apart.
- Simultaneous X and Y wrap (799,524 → 0,0) occurs in a single edge.

## Test plan
- Reset values: hold Reset=0 for 5 Clk with R=G=B=1 → CounterX=CounterY=0, vga_r/g/b=0, both syncs=1, FrameTick=0; PixelTick=0 throughout.
- Pixel rate: release reset → PixelTick toggles 0,1,0,1…; CounterX reaches 10 after 20 Clk from release.
- Horizontal sync: run one line → vga_h_sync low for exactly 96 pixel periods. It falls on the tick edge where CounterX goes 656→657, and line wrap 799→0 increments CounterY to 1.
- Blanking mask: R=G=B=1 constant → vga_r/g/b high only for registered pixels X<640, Y<480; low during X 640..799 and lines 480..524.
- Frame: run two frames → vga_v_sync low for exactly 2 lines (3200 Clk) per frame. FrameTick pulses once per frame, 840000 Clk apart, at (639,479). Counters wrap (799,524)→(0,0).
- Reset mid-frame: assert Reset=0 for 1 Clk at CounterX=700, CounterY=491 (both syncs low) → next edge returns to reset values, syncs=1, and counting restarts from (0,0).
